md5_dispatch_sched: RTL and testbench

//  Schedules candidate strings from string_process_match onto NUM_CORES md5core instances.
//  - Dispatch is round-robin.
//  - Records the byte position each core is working on.
//  - Compares returned digests with target_hash from cmd_parser.
//  - Reports the first match to cmd_parser, which drives bus_done/bus_match.

---
 rtl/md5_dispatch_sched_if.sv | 28 ++
 rtl/md5_dispatch_sched.sv | 190 +++++++++++++++++++
 tb/tb_md5_dispatch_sched.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md5_dispatch_sched_if.sv
// Candidate stream and md5 core bus between the scheduler and its neighbours.
// master: string source plus core array; slave: the scheduler.
interface md5_dispatch_sched_if #(
    parameter int NUM_CORES = 4,
    parameter int STR_BITS  = 512,
    parameter int POS_W     = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [STR_BITS-1:0]      in_str;
    logic [POS_W-1:0]         in_pos;
    logic                     in_last;
    logic [NUM_CORES-1:0]     core_ready;
    logic [NUM_CORES-1:0]     core_start;
    logic [STR_BITS-1:0]      core_msg;
    logic [NUM_CORES-1:0]     core_done;
    logic [NUM_CORES*128-1:0] core_hash;

    modport master (
        output in_valid, in_str, in_pos, in_last, core_ready, core_done, core_hash,
        input  in_ready, core_start, core_msg
    );

    modport slave (
        input  in_valid, in_str, in_pos, in_last, core_ready, core_done, core_hash,
        output in_ready, core_start, core_msg
    );
endinterface

// File: rtl/md5_dispatch_sched.sv
// Round-robin scheduler of candidate blocks onto md5 cores. Each job is tagged
// with its byte position; the first digest equal to target_hash is reported.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting candidates, dispatching to free cores
// DRAIN | last candidate taken, waiting for outstanding digests
// HIT   | match reported, outstanding digests discarded, waiting for clear
module md5_dispatch_sched #(
    parameter int NUM_CORES = 4,
    parameter int STR_BITS  = 512,
    parameter int POS_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                clear,
    input  logic [127:0]        target_hash,
    md5_dispatch_sched_if.slave bus,
    output logic                match,
    output logic [POS_W-1:0]    match_pos,
    output logic                done,
    output logic                busy,
    output logic                proto_err
);
    localparam int RR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HIT} state_t;

    state_t               state_q, state_d;
    logic [RR_W-1:0]      rr_q, rr_d;
    logic [NUM_CORES-1:0] pend_q, pend_d;
    logic [NUM_CORES-1:0] start_q, start_d;
    logic [POS_W-1:0]     tag_q [NUM_CORES];
    logic [POS_W-1:0]     tag_d [NUM_CORES];
    logic [STR_BITS-1:0]  msg_q, msg_d;
    logic                 hit_q, hit_d;
    logic                 match_q, match_d;
    logic [POS_W-1:0]     mpos_q, mpos_d;
    logic                 perr_q, perr_d;
    logic                 clr_q, clr_d;

    logic [NUM_CORES-1:0] elig, sel_oh, done_ok, done_stray;
    logic [RR_W-1:0]      sel_idx, idx_hi, idx_lo;
    logic                 found_hi, any_elig, in_ready_c, accept, done_c;
    logic                 hit_any;
    logic [POS_W-1:0]     hit_pos;

    // Pick the first eligible core at or above rr, else the lowest eligible one.
    always_comb begin
        elig     = bus.core_ready & ~pend_q;
        any_elig = |elig;
        found_hi = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (elig[k]) begin
                idx_lo = RR_W'(k);
                if (k >= int'(rr_q)) begin
                    idx_hi   = RR_W'(k);
                    found_hi = 1'b1;
                end
            end
        end
        sel_idx = found_hi ? idx_hi : idx_lo;
    end

    assign sel_oh     = NUM_CORES'(1) << sel_idx;
    assign in_ready_c = (state_q == S_RUN) && !hit_q && any_elig;
    assign accept     = bus.in_valid && in_ready_c;
    assign done_ok    = bus.core_done & pend_q;
    assign done_stray = bus.core_done & ~pend_q;

    // Digest compare; the smallest tag wins when several cores hit together.
    always_comb begin
        hit_any = 1'b0;
        hit_pos = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (done_ok[k] && (bus.core_hash[128*k +: 128] == target_hash)) begin
                if (!hit_any || (tag_q[k] < hit_pos)) begin
                    hit_pos = tag_q[k];
                end
                hit_any = 1'b1;
            end
        end
    end

    // Next-state, bookkeeping and job-level outputs.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        pend_d  = pend_q & ~done_ok;
        start_d = '0;
        tag_d   = tag_q;
        msg_d   = msg_q;
        hit_d   = 1'b0;
        match_d = match_q;
        mpos_d  = mpos_q;
        perr_d  = perr_q | (|done_stray);
        clr_d   = clr_q;
        done_c  = 1'b0;

        if (accept) begin
            pend_d         = pend_d | sel_oh;
            start_d        = sel_oh;
            tag_d[sel_idx] = bus.in_pos;
            msg_d          = bus.in_str;
            rr_d           = (int'(sel_idx) == NUM_CORES - 1) ? '0 : sel_idx + 1'b1;
        end

        // Only the first match of a job is recorded.
        if ((state_q == S_RUN || state_q == S_DRAIN) && !hit_q && hit_any) begin
            hit_d   = 1'b1;
            match_d = 1'b1;
            mpos_d  = hit_pos;
        end

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (hit_q) begin
                    done_c  = 1'b1;
                    state_d = S_HIT;
                end else if (accept && bus.in_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (hit_q) begin
                    done_c  = 1'b1;
                    state_d = S_HIT;
                end else if (pend_q == '0) begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_HIT: begin
                // A clear arriving while digests are outstanding is remembered.
                if ((clear || clr_q) && (pend_q == '0)) begin
                    state_d = S_IDLE;
                    match_d = 1'b0;
                    clr_d   = 1'b0;
                end else if (clear) begin
                    clr_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and bookkeeping registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            pend_q  <= '0;
            start_q <= '0;
            for (int k = 0; k < NUM_CORES; k++) tag_q[k] <= '0;
            msg_q   <= '0;
            hit_q   <= 1'b0;
            match_q <= 1'b0;
            mpos_q  <= '0;
            perr_q  <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            pend_q  <= pend_d;
            start_q <= start_d;
            tag_q   <= tag_d;
            msg_q   <= msg_d;
            hit_q   <= hit_d;
            match_q <= match_d;
            mpos_q  <= mpos_d;
            perr_q  <= perr_d;
            clr_q   <= clr_d;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.core_start = start_q;
    assign bus.core_msg   = msg_q;
    assign match          = match_q;
    assign match_pos      = mpos_q;
    assign done           = done_c;
    assign busy           = (state_q != S_IDLE);
    assign proto_err      = perr_q;
endmodule

// File: tb/tb_md5_dispatch_sched.sv
// Bench for md5_dispatch_sched: a core array model, a job-level reference model
// checked every cycle, and directed scenarios with hand-computed literals.
module tb_md5_dispatch_sched;
    localparam int NC = 4;
    localparam logic [31:0] K_HIT = 32'h5A5A_0122;
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_HIT = 3;

    logic         clk = 1'b0;
    logic         reset, start, clear;
    logic [127:0] target_hash;
    logic         match, done, busy, proto_err;
    logic [15:0]  match_pos;

    md5_dispatch_sched_if #(.NUM_CORES(NC), .STR_BITS(512), .POS_W(16)) bus ();

    md5_dispatch_sched #(.NUM_CORES(NC), .STR_BITS(512), .POS_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .target_hash(target_hash), .bus(bus), .match(match), .match_pos(match_pos),
        .done(done), .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;
    int n_done = 0;
    int last_done_cyc [NC];
    int last_acc_cyc = -10;
    int start_log [$];
    int lat [NC];
    int stray_req = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [511:0] mk_msg(input logic [31:0] key, input int pos);
        logic [511:0] m;
        m            = '0;
        m[31:0]      = key;
        m[47:32]     = 16'(pos);
        m[255:224]   = 32'(pos * 7 + 1);
        m[511:480]   = 32'hDEAD_BEEF;
        return m;
    endfunction

    // Core array model: fixed per-core latency, digest derived from the message key.
    initial begin : cores
        int cnt [NC];
        bit started [NC];
        logic [31:0] ckey [NC];
        bit rst_seen;
        int stray_ack;
        stray_ack = 0;
        for (int k = 0; k < NC; k++) begin cnt[k] = 0; started[k] = 0; ckey[k] = '0; end
        bus.core_ready = '1;
        bus.core_done  = '0;
        bus.core_hash  = '0;
        forever begin
            @(negedge clk);
            rst_seen = (reset == 1'b0);
            for (int k = 0; k < NC; k++) begin
                if (bus.core_start[k]) begin
                    started[k] = 1;
                    ckey[k]    = bus.core_msg[31:0];
                end
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < NC; k++) begin
                bus.core_done[k] = 1'b0;
                if (rst_seen) begin
                    cnt[k] = 0; started[k] = 0; bus.core_ready[k] = 1'b1;
                end else if (started[k]) begin
                    cnt[k] = lat[k]; started[k] = 0; bus.core_ready[k] = 1'b0;
                end else if (cnt[k] > 0) begin
                    cnt[k]--;
                    if (cnt[k] == 0) begin
                        bus.core_done[k]            = 1'b1;
                        bus.core_hash[128*k +: 128] = {4{ckey[k] ^ 32'h6745_2301}};
                        bus.core_ready[k]           = 1'b1;
                    end
                end
            end
            if (stray_req != stray_ack) begin
                bus.core_done[3] = 1'b1;
                stray_ack++;
            end
        end
    end

    // Reference model of the scheduler, stated as job rules.
    int          m_phase, m_rr, m_start, m_pos;
    bit          m_pend [NC];
    int          m_tag [NC];
    bit          m_hitpend, m_match, m_perr, m_clrreq;
    logic [511:0] m_msg;

    task automatic model_reset();
        m_phase = P_IDLE; m_rr = 0; m_start = -1; m_pos = 0; m_msg = '0;
        m_hitpend = 0; m_match = 0; m_perr = 0; m_clrreq = 0;
        for (int k = 0; k < NC; k++) begin m_pend[k] = 0; m_tag[k] = 0; end
    endtask

    task automatic model_step(input bit e_ready, input bit nopend);
        int sel, hpos;
        bit acc, anyhit, newhit;
        if (!reset) begin
            model_reset();
            return;
        end
        sel = -1;
        for (int i = 0; i < NC; i++) begin
            int c = (m_rr + i) % NC;
            if (sel < 0 && bus.core_ready[c] && !m_pend[c]) sel = c;
        end
        acc    = e_ready && bus.in_valid;
        anyhit = 0;
        hpos   = 0;
        for (int k = 0; k < NC; k++) begin
            if (bus.core_done[k]) begin
                if (!m_pend[k]) m_perr = 1;
                else begin
                    if (bus.core_hash[128*k +: 128] == target_hash) begin
                        if (!anyhit || m_tag[k] < hpos) hpos = m_tag[k];
                        anyhit = 1;
                    end
                    m_pend[k] = 0;
                end
            end
        end
        newhit = anyhit && (m_phase == P_RUN || m_phase == P_DRAIN) && !m_hitpend;
        case (m_phase)
            P_IDLE:  if (start) m_phase = P_RUN;
            P_RUN:   if (m_hitpend) m_phase = P_HIT;
                     else if (acc && bus.in_last) m_phase = P_DRAIN;
            P_DRAIN: if (m_hitpend) m_phase = P_HIT;
                     else if (nopend) m_phase = P_IDLE;
            default: if ((clear || m_clrreq) && nopend) begin
                         m_phase = P_IDLE; m_match = 0; m_clrreq = 0;
                     end else if (clear) m_clrreq = 1;
        endcase
        m_hitpend = newhit;
        if (newhit) begin m_match = 1; m_pos = hpos; end
        m_start = acc ? sel : -1;
        if (acc) begin
            m_msg = bus.in_str; m_pend[sel] = 1; m_tag[sel] = int'(bus.in_pos);
            m_rr = (sel + 1) % NC;
        end
    endtask

    // Per-cycle compare of every DUT output against the model.
    initial begin : cmp
        bit any_el, e_ready, nopend, e_done;
        logic [NC-1:0] e_start;
        model_reset();
        for (int k = 0; k < NC; k++) last_done_cyc[k] = -10;
        @(posedge clk);
        forever begin
            @(negedge clk);
            any_el = 0; nopend = 1;
            for (int k = 0; k < NC; k++) begin
                if (bus.core_ready[k] && !m_pend[k]) any_el = 1;
                if (m_pend[k]) nopend = 0;
            end
            e_ready = (m_phase == P_RUN) && !m_hitpend && any_el;
            e_done  = (m_phase == P_RUN || m_phase == P_DRAIN) &&
                      (m_hitpend || (m_phase == P_DRAIN && nopend));
            e_start = (m_start >= 0) ? (NC'(1) << m_start) : '0;
            check("in_ready", bus.in_ready, e_ready);
            check("done", done, e_done);
            check("busy", busy, m_phase != P_IDLE);
            check("match", match, m_match);
            check("match_pos", match_pos, m_pos);
            check("proto_err", proto_err, m_perr);
            check("core_start", bus.core_start, e_start);
            if (bus.core_start != '0) check("core_msg", bus.core_msg == m_msg, 1);
            if (done) n_done++;
            for (int k = 0; k < NC; k++) if (bus.core_done[k]) last_done_cyc[k] = cyc;
            for (int k = 0; k < NC; k++) if (bus.core_start[k]) start_log.push_back(k);
            if (bus.core_start != '0) check("dispatch_latency", cyc - last_acc_cyc, 1);
            if (bus.in_valid && bus.in_ready) last_acc_cyc = cyc;
            model_step(e_ready, nopend);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(1); clear = 1'b0;
    endtask

    task automatic send(input int pos, input logic [31:0] key, input bit last);
        int n;
        bit got;
        bus.in_valid = 1'b1; bus.in_str = mk_msg(key, pos);
        bus.in_pos = 16'(pos); bus.in_last = last;
        n = 0; got = 0;
        while (!got && n < 2000) begin
            @(negedge clk);
            if (bus.in_ready) got = 1;
            n++;
        end
        check("send_accept", got, 1);
        tick(1);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
    endtask

    // Waits at negedges until busy falls; expiry counts as a failure.
    task automatic wait_idle(input int bound, input string nm);
        int n;
        n = 0;
        while (busy && n < bound) begin @(negedge clk); n++; end
        check(nm, busy, 0);
        tick(1);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n, nd0;
        int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        reset = 1'b0; start = 1'b0; clear = 1'b0;
        target_hash = {4{K_HIT ^ 32'h6745_2301}};
        bus.in_valid = 1'b0; bus.in_str = '0; bus.in_pos = '0; bus.in_last = 1'b0;
        for (int k = 0; k < NC; k++) lat[k] = 64;

        // 1: reset
        tick(2);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_core_start", bus.core_start, 0);
        check("rst_match", match, 0);
        check("rst_done", done, 0);
        check("rst_proto_err", proto_err, 0);
        tick(1);
        reset = 1'b1;
        tick(1);
        check("rst_busy", busy, 0);

        // 2 + 3: round robin, no match, final pos 199
        nd0 = n_done;
        pulse_start();
        for (int p = 0; p < 8; p++) send(p, 32'h1000 + p, 1'b0);
        send(199, 32'h2000, 1'b1);
        n = 0;
        while (!done && n < 1000) begin @(negedge clk); n++; end
        check("t3_done_seen", done, 1);
        tick(5);
        for (int i = 0; i < 8; i++) check("t2_start_order", start_log[i], exp_order[i]);
        check("t3_start_199_core", start_log[8], 0);
        check("t3_done_count", n_done - nd0, 1);
        check("t3_match", match, 0);
        check("t3_busy", busy, 0);

        // 4: single hit at 122; a later matching digest on core 0 is discarded
        lat[0] = 80;
        nd0 = n_done;
        pulse_start();
        send(120, 32'h3000, 1'b0);
        send(121, 32'h3001, 1'b0);
        send(122, K_HIT, 1'b0);
        send(123, K_HIT, 1'b0);
        n = 0;
        while (!match && n < 500) begin @(negedge clk); n++; end
        check("t4_match", match, 1);
        check("t4_match_pos", match_pos, 122);
        check("t4_in_ready", bus.in_ready, 0);
        check("t4_match_latency", cyc - last_done_cyc[3], 1);
        tick(1);
        pulse_clear();
        @(negedge clk);
        check("t4_clear_held", busy, 1);
        wait_idle(200, "t4_idle");
        check("t4_match_pos_hold", match_pos, 122);
        check("t4_match_cleared", match, 0);
        check("t4_done_count", n_done - nd0, 1);

        // 5: simultaneous hits on core 2 (tag 40) and core 0 (tag 44)
        lat[0] = 20; lat[2] = 22;
        nd0 = n_done;
        pulse_start();
        send(41, 32'h4001, 1'b0);
        send(40, K_HIT, 1'b0);
        send(42, 32'h4002, 1'b0);
        send(44, K_HIT, 1'b0);
        n = 0;
        while (!match && n < 500) begin @(negedge clk); n++; end
        check("t5_match_pos", match_pos, 40);
        tick(3);
        check("t5_done_count", n_done - nd0, 1);
        pulse_clear();
        wait_idle(200, "t5_idle");

        // 6: stray digest in IDLE, then reset in the middle of a job
        stray_req++;
        tick(3);
        check("t6_proto_err", proto_err, 1);
        for (int k = 0; k < NC; k++) lat[k] = 64;
        pulse_start();
        send(300, 32'h5000, 1'b0);
        send(301, 32'h5001, 1'b0);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_busy", busy, 0);
        check("t6_core_start", bus.core_start, 0);
        check("t6_proto_err_rst", proto_err, 0);
        tick(1);
        pulse_start();
        send(400, 32'h6000, 1'b1);
        tick(2);
        check("t6_rr_restart", start_log[$], 0);
        wait_idle(200, "t6_idle");
        check("t6_no_proto_err", proto_err, 0);

        tick(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
